// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 raster timing, active-region coordinates and frame-based pattern mode rotation
module vga_timing_ctrl #(
    parameter int   H_ACTIVE        = 640,
    parameter int   H_FP            = 16,
    parameter int   H_SYNC          = 96,
    parameter int   H_BP            = 48,
    parameter int   V_ACTIVE        = 480,
    parameter int   V_FP            = 10,
    parameter int   V_SYNC          = 2,
    parameter int   V_BP            = 33,
    parameter logic SYNC_POL        = 1'b0,
    parameter int   FRAMES_PER_MODE = 60
) (
    input  logic       vga_clk,
    input  logic       RST,
    input  logic       enable,
    input  logic       mode_hold,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic [9:0] xPos,
    output logic [9:0] yPos,
    output logic       frame_start,
    output logic [1:0] mode
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic [9:0] hcnt, vcnt;
    logic [7:0] fcnt;
    logic [1:0] mode_r;
    logic       h_end, v_end, f_end, vis, hs_on, vs_on;
    always_comb begin
        h_end = hcnt == 10'(H_TOTAL - 1);
        v_end = vcnt == 10'(V_TOTAL - 1);
        f_end = fcnt == 8'(FRAMES_PER_MODE - 1);
        vis   = hcnt < 10'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
        hs_on = hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC);
        vs_on = vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC);
    end
    always_ff @(posedge vga_clk) begin
        if (RST) begin
            hcnt        <= '0;
            vcnt        <= '0;
            fcnt        <= '0;
            mode_r      <= '0;
            mode        <= '0;
            xPos        <= '0;
            yPos        <= '0;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            if (enable) begin
                hcnt <= h_end ? '0 : hcnt + 10'd1;
                if (h_end)
                    vcnt <= v_end ? '0 : vcnt + 10'd1;
                if (h_end && v_end && !mode_hold) begin
                    fcnt <= f_end ? '0 : fcnt + 8'd1;
                    if (f_end)
                        mode_r <= mode_r + 2'd1;
                end
            end
            blank_n     <= vis;
            xPos        <= vis ? hcnt : '0;
            yPos        <= vis ? vcnt : '0;
            hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            frame_start <= enable && hcnt == '0 && vcnt == '0;
            mode        <= mode_r;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of raster timing, freeze, mode rotation/hold and mid-frame reset on a reduced geometry
module tb_vga_timing_ctrl;
    logic       vga_clk, RST, enable, mode_hold;
    logic       hsync, vsync, blank_n, frame_start;
    logic [9:0] xPos, yPos;
    logic [1:0] mode;
    int total = 0, bad = 0;
    int pos = 0, emode = 0;
    int nb = 0, nh = 0, nv = 0, nf = 0;
    int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .FRAMES_PER_MODE(2)
    ) dut (
        .vga_clk(vga_clk), .RST(RST), .enable(enable), .mode_hold(mode_hold),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .xPos(xPos), .yPos(yPos),
        .frame_start(frame_start), .mode(mode)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // geometry 16x10: active 8x6, hsync at h=10..12, vsync on lines 7..8
    task automatic run(input int n);
        int h, v, vis;
        for (int k = 0; k < n; k++) begin
            step();
            h   = pos % 16;
            v   = pos / 16;
            vis = (h < 8 && v < 6) ? 1 : 0;
            chk("blank_n", 32'(blank_n), 32'(vis));
            chk("xPos", 32'(xPos), vis ? 32'(h) : 32'd0);
            chk("yPos", 32'(yPos), vis ? 32'(v) : 32'd0);
            chk("hsync", 32'(hsync), (h >= 10 && h <= 12) ? 32'd0 : 32'd1);
            chk("vsync", 32'(vsync), (v == 7 || v == 8) ? 32'd0 : 32'd1);
            chk("frame_start", 32'(frame_start), (pos == 0) ? 32'd1 : 32'd0);
            chk("mode", 32'(mode), 32'(emode));
            nb += int'(blank_n);
            nh += int'(!hsync);
            nv += int'(!vsync);
            nf += int'(frame_start);
            pos = (pos + 1) % 160;
        end
    endtask

    initial begin
        RST = 1'b1; enable = 1'b0; mode_hold = 1'b0;
        step();
        step();
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_blank", 32'(blank_n), 32'd0);
        chk("rst_x", 32'(xPos), 32'd0);
        chk("rst_y", 32'(yPos), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        RST = 1'b0;
        step();
        chk("idle00_fs", 32'(frame_start), 32'd0);
        chk("idle00_blank", 32'(blank_n), 32'd1);
        enable = 1'b1;
        run(160);
        chk("cnt_blank", 32'(nb), 32'd48);
        chk("cnt_hsync_low", 32'(nh), 32'd30);
        chk("cnt_vsync_low", 32'(nv), 32'd32);
        chk("cnt_frame_start", 32'(nf), 32'd1);
        run(53);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("frz_x", 32'(xPos), 32'd5);
            chk("frz_y", 32'(yPos), 32'd3);
            chk("frz_blank", 32'(blank_n), 32'd1);
            chk("frz_fs", 32'(frame_start), 32'd0);
            chk("frz_hsync", 32'(hsync), 32'd1);
        end
        enable = 1'b1;
        run(1);
        chk("resume_x0", 32'(xPos), 32'd5);
        run(1);
        chk("resume_x1", 32'(xPos), 32'd6);
        run(105);
        for (int f = 2; f < 9; f++) begin
            emode = seq[f];
            run(160);
        end
        mode_hold = 1'b1;
        emode = 0;
        run(800);
        mode_hold = 1'b0;
        run(160);
        emode = 1;
        run(1);
        chk("hold_resume_mode", 32'(mode), 32'd1);
        run(159);
        run(160);
        emode = 2;
        run(139);
        chk("pre_rst_mode", 32'(mode), 32'd2);
        chk("pre_rst_hsync", 32'(hsync), 32'd0);
        chk("pre_rst_vsync", 32'(vsync), 32'd0);
        RST = 1'b1;
        step();
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vsync), 32'd1);
        chk("mid_rst_blank", 32'(blank_n), 32'd0);
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        RST = 1'b0;
        pos = 0;
        emode = 0;
        run(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
